// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one single-outstanding memory port among
// NUM_MASTERS requesters using fixed-priority or round-robin arbitration,
// with an optional response timeout that completes the stalled transaction
// with an error.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   m_read_request          per-master read request (level)
//   m_write_request         per-master write request (level, wins over read)
//   m_addr, m_write_data    packed per-master address / write data
//   m_response, m_error     one-cycle completion pulse and its error qualifier
//   m_read_data             shared read data, valid with m_response
//   memory_*                single memory port (request levels, addr, data,
//                           response, read data)
//   grant_valid, grant_id   current owner of the memory port
module memory_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    localparam int unsigned GW = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_MASTERS-1:0]           m_read_request,
    input  logic [NUM_MASTERS-1:0]           m_write_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data,
    output logic [NUM_MASTERS-1:0]           m_response,
    output logic [NUM_MASTERS-1:0]           m_error,
    output logic [DATA_WIDTH-1:0]            m_read_data,
    output logic                             memory_read_request,
    output logic                             memory_write_request,
    output logic [ADDR_WIDTH-1:0]            memory_addr,
    output logic [DATA_WIDTH-1:0]            memory_write_data,
    input  logic                             memory_response,
    input  logic [DATA_WIDTH-1:0]            memory_read_data,
    output logic                             grant_valid,
    output logic [GW-1:0]                    grant_id
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           gid_q, gid_d;
    logic [GW-1:0]           last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    mem_rd_q, mem_rd_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [NUM_MASTERS-1:0]  resp_q, resp_d;
    logic [NUM_MASTERS-1:0]  error_q, error_d;
    logic                    gv_q, gv_d;

    logic [NUM_MASTERS-1:0]  req_c;
    int                      win_c;

    assign req_c = m_read_request | m_write_request;

    // Winner selection. Loops run from lowest to highest priority so the
    // last hit is the winner.
    always_comb begin
        int idx;
        win_c = 0;
        idx   = 0;
        if (ARB_MODE == 0) begin
            for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
                if (req_c[i]) win_c = i;
            end
        end else begin
            for (int off = int'(NUM_MASTERS); off >= 1; off--) begin
                idx = int'(last_q) + off;
                if (idx >= int'(NUM_MASTERS)) idx = idx - int'(NUM_MASTERS);
                if (req_c[idx]) win_c = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        gid_d    = gid_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        resp_d   = '0;
        error_d  = '0;

        case (state_q)
            IDLE: begin
                if (|req_c) begin
                    state_d  = BUSY;
                    gid_d    = GW'(win_c);
                    last_d   = GW'(win_c);
                    addr_d   = m_addr[win_c*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = m_write_data[win_c*DATA_WIDTH +: DATA_WIDTH];
                    cnt_d    = '0;
                    mem_wr_d = m_write_request[win_c];
                    mem_rd_d = ~m_write_request[win_c];
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (memory_response) begin
                    state_d         = RESP;
                    rdata_d         = mem_wr_q ? '0 : memory_read_data;
                    mem_rd_d        = 1'b0;
                    mem_wr_d        = 1'b0;
                    resp_d[gid_q]   = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
                    // Last allowed BUSY cycle passed with no response.
                    state_d         = RESP;
                    rdata_d         = '0;
                    mem_rd_d        = 1'b0;
                    mem_wr_d        = 1'b0;
                    resp_d[gid_q]   = 1'b1;
                    error_d[gid_q]  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gv_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gid_q    <= '0;
            last_q   <= GW'(NUM_MASTERS - 1);
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            resp_q   <= '0;
            error_q  <= '0;
            gv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            resp_q   <= resp_d;
            error_q  <= error_d;
            gv_q     <= gv_d;
        end
    end

    assign m_response           = resp_q;
    assign m_error              = error_q;
    assign m_read_data          = rdata_q;
    assign memory_read_request  = mem_rd_q;
    assign memory_write_request = mem_wr_q;
    assign memory_addr          = addr_q;
    assign memory_write_data    = wdata_q;
    assign grant_valid          = gv_q;
    assign grant_id             = gid_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter. Instance A: 3 masters, fixed priority,
// timeout 8. Instance B: 4 masters, round robin, no timeout.
// Expected responses and memory operations are queued by the stimulus and
// popped by independent monitors.
module tb_memory_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NA = 3;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- instance A ----------------
    logic              rst_n_a;
    logic [NA-1:0]     rd_a, wr_a;
    logic [NA*AW-1:0]  addr_a;
    logic [NA*DW-1:0]  wdata_a;
    logic [NA-1:0]     resp_a, err_a;
    logic [DW-1:0]     rdata_a;
    logic              mrd_a, mwr_a;
    logic [AW-1:0]     maddr_a;
    logic [DW-1:0]     mwdata_a;
    logic              mresp_a;
    logic [DW-1:0]     mrdata_a = '0;
    logic              gv_a;
    logic [1:0]        gid_a;
    logic              model_resp_a = 1'b0;
    logic              stray_a = 1'b0;
    int                lat_a = 1;
    int                mcnt_a = 0;
    logic              done_a = 1'b0;

    assign mresp_a = model_resp_a | stray_a;

    memory_bus_arbiter #(
        .NUM_MASTERS(NA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ARB_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .m_read_request(rd_a), .m_write_request(wr_a),
        .m_addr(addr_a), .m_write_data(wdata_a),
        .m_response(resp_a), .m_error(err_a), .m_read_data(rdata_a),
        .memory_read_request(mrd_a), .memory_write_request(mwr_a),
        .memory_addr(maddr_a), .memory_write_data(mwdata_a),
        .memory_response(mresp_a), .memory_read_data(mrdata_a),
        .grant_valid(gv_a), .grant_id(gid_a)
    );

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mop_t;

    resp_t rq[$];
    mop_t  mq[$];

    // Memory model: responds in the lat_a-th cycle the request is seen
    // (lat_a == 0 never responds); data is {addr[15:0], 16'hC0DE}.
    always @(negedge clk) begin
        if (mrd_a | mwr_a) begin
            mcnt_a       = mcnt_a + 1;
            model_resp_a = (lat_a != 0) && (mcnt_a == lat_a);
            mrdata_a     = {maddr_a[15:0], 16'hC0DE};
        end else begin
            mcnt_a       = 0;
            model_resp_a = 1'b0;
            mrdata_a     = '0;
        end
    end

    // Memory-side monitor: checks each new memory request.
    logic mreq_prev_a = 1'b0;
    always @(negedge clk) begin
        mop_t e;
        if ((mrd_a | mwr_a) && !mreq_prev_a) begin
            if (mq.size() == 0) begin
                chk("mem_unexpected", 64'({mrd_a, mwr_a}), 64'd0);
            end else begin
                e = mq.pop_front();
                chk("mem_write_req", 64'(mwr_a), 64'(e.wr));
                chk("mem_read_req", 64'(mrd_a), 64'(!e.wr));
                chk("mem_addr", 64'(maddr_a), 64'(e.addr));
                if (e.wr) chk("mem_wdata", 64'(mwdata_a), 64'(e.wdata));
            end
        end
        mreq_prev_a = mrd_a | mwr_a;
    end

    // Master-side monitor: checks each completion pulse.
    always @(negedge clk) begin
        resp_t e;
        if (resp_a != '0) begin
            if (rq.size() == 0) begin
                chk("resp_unexpected", 64'(resp_a), 64'd0);
            end else begin
                e = rq.pop_front();
                chk("resp_vec", 64'(resp_a), 64'(1) << e.id);
                chk("err_vec", 64'(err_a), e.err ? (64'(1) << e.id) : 64'd0);
                chk("read_data", 64'(rdata_a), 64'(e.data));
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_gid", 64'(gid_a), 64'(e.id));
            end
        end
    end

    task automatic set_a(input int i, input logic r, input logic w,
                         input logic [31:0] ad, input logic [31:0] wd);
        rd_a[i] = r;
        wr_a[i] = w;
        addr_a[i*AW +: AW]  = ad;
        wdata_a[i*DW +: DW] = wd;
    endtask

    // Masters drop requests at the edge ending their RESP cycle.
    task automatic drain_a(input int maxc);
        int n;
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            for (int i = 0; i < int'(NA); i++) begin
                if (resp_a[i]) begin
                    rd_a[i] = 1'b0;
                    wr_a[i] = 1'b0;
                end
            end
            if (rd_a == '0 && wr_a == '0 && !gv_a) break;
            n++;
        end
        if (n >= maxc) bound_fail("drain_a");
    endtask

    initial begin
        int c0;
        int n;
        rst_n_a = 1'b0;
        rd_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        chk("a_rst_grant_valid", 64'(gv_a), 64'd0);
        chk("a_rst_mem_req", 64'({mrd_a, mwr_a}), 64'd0);
        chk("a_rst_resp", 64'(resp_a), 64'd0);

        // Fixed priority: masters 0 and 2 read together, latency 1.
        lat_a = 1;
        c0 = cyc;
        set_a(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_a(2, 1'b1, 1'b0, 32'h0000_0208, 32'h0);
        mq.push_back('{1'b0, 32'h0000_0100, 32'h0});
        mq.push_back('{1'b0, 32'h0000_0208, 32'h0});
        rq.push_back('{0, 1'b0, 32'h0100_C0DE, c0 + 2});
        rq.push_back('{2, 1'b0, 32'h0208_C0DE, c0 + 5});
        drain_a(40);

        // Write precedence: read and write together on master 1.
        lat_a = 2;
        c0 = cyc;
        set_a(1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        mq.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF});
        rq.push_back('{1, 1'b0, 32'h0, c0 + 3});
        drain_a(40);

        // Request withdrawn in the second BUSY cycle still completes.
        lat_a = 4;
        c0 = cyc;
        set_a(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        mq.push_back('{1'b0, 32'h0000_0300, 32'h0});
        rq.push_back('{0, 1'b0, 32'h0300_C0DE, c0 + 5});
        @(negedge clk);
        @(negedge clk);
        rd_a[0] = 1'b0;
        drain_a(40);

        // Timeout: memory never answers; stray responses later are ignored.
        lat_a = 0;
        c0 = cyc;
        set_a(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        mq.push_back('{1'b0, 32'h0000_0500, 32'h0});
        rq.push_back('{1, 1'b1, 32'h0, c0 + 9});
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (resp_a[1]) break;
            n++;
        end
        if (n >= 20) bound_fail("timeout_wait");
        rd_a[1] = 1'b0;
        stray_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_resp_grant_valid", 64'(gv_a), 64'd0);
        chk("late_resp_mem_req", 64'({mrd_a, mwr_a}), 64'd0);

        // Reset in the middle of BUSY.
        set_a(2, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        mq.push_back('{1'b0, 32'h0000_0600, 32'h0});
        repeat (3) @(negedge clk);
        rst_n_a = 1'b0;
        rd_a = '0;
        #1;
        chk("a_midrst_resp", 64'(resp_a), 64'd0);
        chk("a_midrst_err", 64'(err_a), 64'd0);
        chk("a_midrst_rdata", 64'(rdata_a), 64'd0);
        chk("a_midrst_mem_req", 64'({mrd_a, mwr_a}), 64'd0);
        chk("a_midrst_mem_addr", 64'(maddr_a), 64'd0);
        chk("a_midrst_grant", 64'({gv_a, gid_a}), 64'd0);
        @(negedge clk);
        rst_n_a = 1'b1;

        // After reset master 0 is served first.
        lat_a = 1;
        c0 = cyc;
        set_a(0, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        set_a(2, 1'b1, 1'b0, 32'h0000_0710, 32'h0);
        mq.push_back('{1'b0, 32'h0000_0700, 32'h0});
        mq.push_back('{1'b0, 32'h0000_0710, 32'h0});
        rq.push_back('{0, 1'b0, 32'h0700_C0DE, c0 + 2});
        rq.push_back('{2, 1'b0, 32'h0710_C0DE, c0 + 5});
        drain_a(40);

        repeat (3) @(negedge clk);
        chk("a_resp_queue_empty", 64'(rq.size()), 64'd0);
        chk("a_mem_queue_empty", 64'(mq.size()), 64'd0);
        done_a = 1'b1;
    end

    // ---------------- instance B ----------------
    logic              rst_n_b;
    logic [NB-1:0]     rd_b;
    logic [NB-1:0]     wr_b = '0;
    logic [NB*AW-1:0]  addr_b = '0;
    logic [NB*DW-1:0]  wdata_b = '0;
    logic [NB-1:0]     resp_b, err_b;
    logic [DW-1:0]     rdata_b;
    logic              mrd_b, mwr_b;
    logic [AW-1:0]     maddr_b;
    logic [DW-1:0]     mwdata_b;
    logic              mresp_b = 1'b0;
    logic [DW-1:0]     mrdata_b = 32'h1234_5678;
    logic              gv_b;
    logic [1:0]        gid_b;
    int                mcnt_b = 0;
    int                nb = 0;
    logic              done_b = 1'b0;
    int                gq[$];

    memory_bus_arbiter #(
        .NUM_MASTERS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ARB_MODE(1), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .m_read_request(rd_b), .m_write_request(wr_b),
        .m_addr(addr_b), .m_write_data(wdata_b),
        .m_response(resp_b), .m_error(err_b), .m_read_data(rdata_b),
        .memory_read_request(mrd_b), .memory_write_request(mwr_b),
        .memory_addr(maddr_b), .memory_write_data(mwdata_b),
        .memory_response(mresp_b), .memory_read_data(mrdata_b),
        .grant_valid(gv_b), .grant_id(gid_b)
    );

    // Memory model B: fixed latency of 3 cycles.
    always @(negedge clk) begin
        if (mrd_b | mwr_b) begin
            mcnt_b  = mcnt_b + 1;
            mresp_b = (mcnt_b == 3);
        end else begin
            mcnt_b  = 0;
            mresp_b = 1'b0;
        end
    end

    // Grant monitor: checks the owner at the start of each transaction.
    logic gvprev_b = 1'b0;
    always @(negedge clk) begin
        int e;
        if (gv_b && !gvprev_b) begin
            nb++;
            if (gq.size() == 0) begin
                chk("rr_unexpected_grant", 64'(gid_b), 64'hFF);
            end else begin
                e = gq.pop_front();
                chk("rr_grant_id", 64'(gid_b), 64'(e));
            end
        end
        gvprev_b = gv_b;
    end

    initial begin
        int n;
        rst_n_b = 1'b0;
        rd_b = '0;
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1;
        @(negedge clk);
        gq.push_back(0);
        gq.push_back(1);
        gq.push_back(2);
        gq.push_back(3);
        gq.push_back(0);
        rd_b = 4'hF;
        n = 0;
        while (nb < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) bound_fail("rr_five_grants");

        // Reset mid-BUSY with all requests still held.
        @(negedge clk);
        rst_n_b = 1'b0;
        #1;
        chk("b_midrst_grant", 64'({gv_b, gid_b}), 64'd0);
        chk("b_midrst_mem_req", 64'({mrd_b, mwr_b}), 64'd0);
        chk("b_midrst_resp", 64'(resp_b), 64'd0);
        @(negedge clk);
        gq.push_back(0);
        rst_n_b = 1'b1;
        n = 0;
        while (nb < 6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) bound_fail("rr_grant_after_reset");
        rd_b = '0;
        repeat (8) @(negedge clk);
        chk("b_idle_after_drop", 64'(gv_b), 64'd0);
        chk("b_grant_queue_empty", 64'(gq.size()), 64'd0);
        done_b = 1'b1;
    end

    // Completion and summary.
    initial begin
        int n;
        n = 0;
        while (!(done_a && done_b) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) bound_fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Parametrised N-master arbiter that shares one single-outstanding memory port among NUM_MASTERS cache/bus requesters, for example I-cache, D-cache and a DMA or debug master. It generalises the fixed two-port cache request multiplexer with:
- configurable master count and bus widths,
- selectable fixed-priority or round-robin arbitration,
- an optional response timeout that returns an error to the stalled master.

It sits between the core-side caches and the external memory bus.

## Interface
- NUM_MASTERS, 2, number of requesting masters (2..8)
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- ARB_MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin
- TIMEOUT_CYCLES, 0, memory response timeout in cycles; 0 disables the timeout
- GW (localparam) = max(1, $clog2(NUM_MASTERS))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_read_request  in  NUM_MASTERS  per-master read request, level
- m_write_request  in  NUM_MASTERS  per-master write request, level
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_write_data  in  NUM_MASTERS*DATA_WIDTH  packed write data, same slicing rule
- m_response  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- m_error  out  NUM_MASTERS  qualifies m_response; 1 = timed out
- m_read_data  out  DATA_WIDTH  shared read data; valid only while m_response is high
- memory_read_request  out  1  memory read, level
- memory_write_request  out  1  memory write, level
- memory_addr  out  ADDR_WIDTH  memory address
- memory_write_data  out  DATA_WIDTH  memory write data
- memory_response  in  1  memory completion; read data valid in the same cycle
- memory_read_data  in  DATA_WIDTH  memory read data
- grant_valid  out  1  high while a transaction is owned (BUSY or RESP)
- grant_id  out  GW  index of the owning master

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, any master has a read or write request:
  - select the winner by ARB_MODE;
  - register its index, address, write data and operation;
  - go to BUSY.
- Both read and write asserted on the same master: the operation is a write.
- Fixed priority: the lowest asserted index wins.
- Round robin:
  - search starts at last_grant+1 and wraps modulo NUM_MASTERS;
  - last_grant is updated on every grant;
  - last_grant resets to NUM_MASTERS-1, so master 0 is favoured first.
- BUSY:
  - drive exactly one of memory_read_request or memory_write_request, using the registered address and data;
  - on memory_response, capture memory_read_data (write transactions return 0), drop the memory request and go to RESP.
- Timeout (TIMEOUT_CYCLES>0):
  - a counter clears on entry to BUSY and counts each BUSY cycle;
  - when the counter reaches TIMEOUT_CYCLES with no memory_response, drop the memory request, set the error flag and go to RESP;
  - on a timeout, m_read_data is 0.
- RESP:
  - m_response[grant_id]=1 for exactly one cycle;
  - m_error[grant_id] = error flag;
  - then go to IDLE.
- Master rules:
  - a master holds its request, address and data stable until it sees m_response;
  - it drops the request at the clock edge that ends the RESP cycle;
  - a request re-asserted in IDLE starts a new transaction.
- Request dropped mid-transaction: the transaction still completes and m_response is still pulsed.
- memory_response arriving in IDLE or RESP, including a late response after a timeout: ignored.
- Reset, at any time:
  - state goes to IDLE and the timeout counter clears;
  - every output is 0;
  - last_grant returns to NUM_MASTERS-1.
  - An in-flight memory transaction is abandoned.

## Timing
- Cycle 0: master raises its request while the FSM is in IDLE. Cycle 1: memory request asserted.
- Memory responds in cycle r (r ≥ 1): m_response is in cycle r+1. Cycle r+2: FSM in IDLE.
- Minimum latency, request to m_response: 2 cycles.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- Outputs are fully registered; there is no combinational path from any input to any output.
- Timeout: m_response with m_error=1 in cycle TIMEOUT_CYCLES+1 after BUSY entry.

## Test plan
- Reset: assert rst_n=0 mid-BUSY -> all outputs 0 immediately; after release, master 0's request is granted first.
- Fixed priority, NUM_MASTERS=3:
  - masters 0 and 2 request reads simultaneously, memory latency 1;
  - -> master 0 served first (m_response[0] in cycle 2), then master 2;
  - m_read_data matches memory_read_data each time.
- Round robin, NUM_MASTERS=4, all four request continuously -> grant_id sequence 0,1,2,3,0.
- Write precedence: master 1 asserts read and write, addr 0x00000040, data 0xDEADBEEF -> memory_write_request=1 with that address and data; memory_read_request stays 0.
- Timeout, TIMEOUT_CYCLES=8, memory never responds:
  - -> m_response and m_error on the granted master in cycle 9 after BUSY entry, m_read_data=0;
  - a later memory_response is ignored.
- Withdrawn request: master drops its request in cycle 2 of BUSY -> memory transaction completes and m_response is still pulsed.
